register_bank_pipe: RTL and testbench



---
 rtl/register_bank_pipe.sv | 107 ++++++++++
 tb/tb_register_bank_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/register_bank_pipe.sv
// 2R/1W register bank with register-0 hardwiring and a sequential scrub engine.
// Optional same-cycle write-to-read forwarding: define REGBANK_BYPASS_EN.
module register_bank_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  RegWrite,
  input  logic                  ClearReq,
  output logic                  Busy,
  output logic                  ClearDone
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } scrubState_t;

  scrubState_t state;
  logic [ADDR_WIDTH-1:0] counter;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wrEn;

  function automatic logic isZero(
    input logic [ADDR_WIDTH-1:0] a
  );
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wrEn = RegWrite && !Busy
             && !isZero(WriteRegister);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      counter   <= '0;
      Busy      <= 1'b0;
      ClearDone <= 1'b0;
    end else begin
      ClearDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ClearReq) begin
            state   <= CLEAR;
            counter <= '0;
            Busy    <= 1'b1;
          end
        end
        CLEAR: begin
          counter <= counter + 1'b1;
          if (counter == LAST) begin
            state     <= DONE;
            ClearDone <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  // Writes and scrub clears never coincide: writes are gated by Busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[counter] <= '0;
    end else if (wrEn) begin
      mem[WriteRegister] <= WriteData;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rd(
    input logic [ADDR_WIDTH-1:0] a
  );
    if (isZero(a))
      return '0;
`ifdef REGBANK_BYPASS_EN
    if (wrEn && (a == WriteRegister))
      return WriteData;
`endif
    return mem[a];
  endfunction

  assign ReadData1 = rd(ReadRegister1);
  assign ReadData2 = rd(ReadRegister2);

endmodule

// File: tb/tb_register_bank_pipe.sv
// Directed self-checking bench for register_bank_pipe.
// Bypass expectations follow REGBANK_BYPASS_EN.
module tb_register_bank_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [31:0] ReadData1, ReadData2;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite, ClearReq;
  logic        Busy, ClearDone;

  int nChecks = 0;
  int nFails  = 0;

  register_bank_pipe dut (
    .clk           (clk),
    .reset         (reset),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .RegWrite      (RegWrite),
    .ClearReq      (ClearReq),
    .Busy          (Busy),
    .ClearDone     (ClearDone)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(
    input logic [4:0]  a,
    input logic [31:0] d
  );
    RegWrite      = 1'b1;
    WriteRegister = a;
    WriteData     = d;
    step();
    RegWrite = 1'b0;
  endtask

  task automatic rdChk(
    input string       tag,
    input logic [4:0]  a,
    input logic [31:0] exp
  );
    ReadRegister1 = a;
    ReadRegister2 = a;
    #1;
    check({tag, "_p1"}, ReadData1, exp);
    check({tag, "_p2"}, ReadData2, exp);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (Busy && n < 100) begin
      step();
      n++;
    end
    check("idleTimeout", 32'(Busy), 32'd0);
  endtask

  int busyCycles;
  int donePulses;
  logic [31:0] bypExp;

  initial begin
    reset = 1'b1;
    ReadRegister1 = '0;
    ReadRegister2 = '0;
    WriteRegister = '0;
    WriteData = '0;
    RegWrite = 1'b0;
    ClearReq = 1'b0;
    step();
    reset = 1'b0;

    check("rstBusy", 32'(Busy), 32'd0);
    check("rstDone", 32'(ClearDone), 32'd0);
    for (int i = 0; i < 32; i++)
      rdChk("rstRead", 5'(i), 32'd0);

    wr(5'd5, 32'hDEADBEEF);
    wr(5'd31, 32'h12345678);
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd31;
    #1;
    check("wr5", ReadData1, 32'hDEADBEEF);
    check("wr31", ReadData2, 32'h12345678);
    wr(5'd0, 32'hFFFFFFFF);
    rdChk("zeroReg", 5'd0, 32'd0);

`ifdef REGBANK_BYPASS_EN
    bypExp = 32'hA5A5A5A5;
`else
    bypExp = 32'h0;
`endif
    RegWrite      = 1'b1;
    WriteRegister = 5'd7;
    WriteData     = 32'hA5A5A5A5;
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd0;
    #1;
    check("bypass", ReadData1, bypExp);
    check("bypassZero", ReadData2, 32'd0);
    step();
    RegWrite = 1'b0;
    rdChk("afterWr7", 5'd7, 32'hA5A5A5A5);

    for (int i = 1; i < 32; i++)
      wr(5'(i), 32'(i));
    rdChk("fill17", 5'd17, 32'd17);

    ClearReq = 1'b1;
    step();
    ClearReq = 1'b0;
    busyCycles = 0;
    donePulses = 0;
    while (Busy && busyCycles < 100) begin
      busyCycles++;
      if (ClearDone)
        donePulses++;
      if (busyCycles == 10) begin
        rdChk("partCleared", 5'd8, 32'd0);
        rdChk("partKept", 5'd20, 32'd20);
        RegWrite      = 1'b1;
        WriteRegister = 5'd3;
        WriteData     = 32'h55;
      end
      step();
      RegWrite = 1'b0;
    end
    check("busyCycles", busyCycles, 33);
    check("donePulses", donePulses, 1);
    check("doneLow", 32'(ClearDone), 32'd0);
    rdChk("droppedWr3", 5'd3, 32'd0);
    for (int i = 0; i < 32; i++)
      rdChk("scrubbed", 5'(i), 32'd0);

    ClearReq      = 1'b1;
    RegWrite      = 1'b1;
    WriteRegister = 5'd9;
    WriteData     = 32'h99;
    step();
    ClearReq = 1'b0;
    RegWrite = 1'b0;
    check("startBusy", 32'(Busy), 32'd1);
    rdChk("sameCycleWr", 5'd9, 32'h99);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abortBusy", 32'(Busy), 32'd0);
    check("abortDone", 32'(ClearDone), 32'd0);
    rdChk("abortClr9", 5'd9, 32'd0);
    step();
    check("abortNoDone", 32'(ClearDone), 32'd0);
    check("abortIdle", 32'(Busy), 32'd0);

    wr(5'd1, 32'h11);
    wr(5'd30, 32'h30);
    ClearReq = 1'b1;
    step();
    ClearReq = 1'b0;
    rdChk("restart1Kept", 5'd1, 32'h11);
    step();
    step();
    rdChk("restart1Clr", 5'd1, 32'd0);
    rdChk("restart30Kept", 5'd30, 32'h30);
    waitIdle();
    rdChk("restart30Clr", 5'd30, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
